// File: rtl/dft_pkg.sv
// Shared types for the DFT compute path: index width, sequencer states
// and the index typedef used by the cache, ROM and MAC controllers.
package dft_pkg;

   localparam int IDX_W_DEF = 12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef logic [IDX_W_DEF-1:0] idx_t;

endpackage

// File: rtl/tw_idx_acc.sv
// Twiddle index accumulator: tw steps by k modulo n_pts without a multiplier.
// Relies on tw < n_pts and k < n_pts, so one conditional subtract suffices.
module tw_idx_acc
   import dft_pkg::*;
#(
   parameter int W = IDX_W_DEF
) (
   input  logic         clk,
   input  logic         nrst,
   input  logic         clear,
   input  logic         step,
   input  logic [W-1:0] k,
   input  logic [W-1:0] n_pts,
   output logic [W-1:0] tw
);

   logic [W:0] sum;
   logic [W:0] lim;

   assign sum = {1'b0, tw} + {1'b0, k};
   assign lim = {1'b0, n_pts};

   always_ff @(posedge clk) begin
      if (!nrst) begin
         tw <= '0;
      end else if (clear) begin
         tw <= '0;
      end else if (step) begin
         tw <= W'((sum >= lim) ? (sum - lim) : sum);
      end
   end

endmodule

// File: rtl/dft_index_sequencer.sv
// Walks bin k (outer) and sample n (inner) as a stallable valid/ready stream.
// DFT_SEQ_HALF_SPECTRUM_EN limits bins to 0..N/2; otherwise 0..N-1.
module dft_index_sequencer
   import dft_pkg::*;
#(
   parameter int IDX_W = IDX_W_DEF
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             ce,
   input  logic             start,
   input  logic             abort,
   input  logic [IDX_W-1:0] sample_num,
   input  logic             ready,
   output logic             valid,
   output logic [IDX_W-1:0] n_idx,
   output logic [IDX_W-1:0] k_idx,
   output logic [IDX_W-1:0] tw_idx,
   output logic             first,
   output logic             last,
   output logic             calc_end,
   output logic             busy,
   output logic [1:0]       state
);

   state_t           st;
   logic [IDX_W-1:0] n_pts;
   logic [IDX_W-1:0] k_last;
   logic [IDX_W-1:0] k_last_in;
   logic             xfer;
   logic             n_end;
   logic             k_end;
   logic             go;
   logic             abt;
   logic             step;
   logic             clear;

`ifdef DFT_SEQ_HALF_SPECTRUM_EN
   assign k_last_in = sample_num >> 1;
`else
   assign k_last_in = sample_num - IDX_W'(1);
`endif

   assign xfer  = valid & ready & ce;
   assign n_end = (n_idx == n_pts - IDX_W'(1));
   assign k_end = (k_idx == k_last);
   assign go    = (st == IDLE) & start & (sample_num != '0);
   assign abt   = abort & (st != IDLE);
   assign step  = xfer & ~abt & ~n_end;
   assign clear = ce & (go | abt | (xfer & n_end));

   assign state = st;
   assign busy  = (st != IDLE);

   tw_idx_acc #(.W(IDX_W)) u_acc (
      .clk   (clk),
      .nrst  (nrst),
      .clear (clear),
      .step  (step),
      .k     (k_idx),
      .n_pts (n_pts),
      .tw    (tw_idx)
   );

   always_ff @(posedge clk) begin
      if (!nrst) begin
         st       <= IDLE;
         valid    <= 1'b0;
         n_idx    <= '0;
         k_idx    <= '0;
         first    <= 1'b0;
         last     <= 1'b0;
         calc_end <= 1'b0;
         n_pts    <= '0;
         k_last   <= '0;
      end else if (ce) begin
         if (abt) begin
            // abort wins over any transfer in the same cycle
            st       <= IDLE;
            valid    <= 1'b0;
            n_idx    <= '0;
            k_idx    <= '0;
            first    <= 1'b0;
            last     <= 1'b0;
            calc_end <= 1'b0;
         end else begin
            case (st)
               IDLE: begin
                  if (go) begin
                     st     <= RUN;
                     n_pts  <= sample_num;
                     k_last <= k_last_in;
                     valid  <= 1'b1;
                     n_idx  <= '0;
                     k_idx  <= '0;
                     first  <= 1'b1;
                     last   <= (sample_num == IDX_W'(1));
                  end
               end
               RUN: begin
                  if (ready) begin
                     if (!n_end) begin
                        n_idx <= n_idx + IDX_W'(1);
                        first <= 1'b0;
                        last  <= (n_idx + IDX_W'(2) == n_pts);
                     end else if (!k_end) begin
                        n_idx <= '0;
                        k_idx <= k_idx + IDX_W'(1);
                        first <= 1'b1;
                        last  <= (n_pts == IDX_W'(1));
                     end else begin
                        st       <= DONE;
                        valid    <= 1'b0;
                        first    <= 1'b0;
                        last     <= 1'b0;
                        calc_end <= 1'b1;
                     end
                  end
               end
               DONE: begin
                  st       <= IDLE;
                  calc_end <= 1'b0;
               end
               default: begin
                  st    <= IDLE;
                  valid <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
